if_fetch: RTL and testbench

- Instruction-fetch front end; the producer side of the if_pc/if_inst interface consumed by the IF/ID pipeline register.
- Owns the PC and runs a req/ack handshake with instruction memory.
- Presents one fetched instruction at a time, or ZeroWord (nop) when none is ready.
- Honours the stage-0 stall bit, branch redirects from ID and flush redirects from the exception path.
- Raises a stall request to the stall controller while waiting on memory.

---
 rtl/if_fetch.sv | 187 ++++++++++++++++++
 tb/tb_if_fetch.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch front end feeding the IF/ID pipeline register.
// Owns the PC, runs a req/ack handshake with instruction memory, presents one
// instruction at a time (ZeroWord otherwise), and honours stall[0], ID branch
// redirects (delay-slot semantics) and exception flush redirects.
// Optional build macro IF_FETCH_CNT_EN adds the fetch_cnt consumption counter.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_if
`ifdef IF_FETCH_CNT_EN
  ,
  output logic [31:0] fetch_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_br_pend;
  logic [31:0] r_br_tgt;
  logic        r_discard;

  logic [31:0] w_pc_nxt;
  logic [31:0] w_inst_nxt;
  logic        w_br_pend_nxt;
  logic [31:0] w_br_tgt_nxt;
  logic        w_discard_nxt;

  logic        w_stop;
  logic        w_consume;
  logic        w_ack_take;
  logic [31:0] w_pc_inc;

  // Only the IF bit of the stall bus matters to this stage.
  logic        w_unused_stall;
  assign w_unused_stall = ^stall[5:1];

  assign w_stop     = stall[0];
  // Flush outranks consumption: a flushed presentation is not consumed.
  assign w_consume  = (r_state == S_VALID) && !w_stop && !flush_i;
  assign w_ack_take = (r_state == S_WAIT) && imem_ack;
  assign w_pc_inc   = r_pc + 32'd4;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: flush always lands in S_WAIT; a discarded ack stays there.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (flush_i) begin
          w_state_nxt = S_WAIT;
        end else if (imem_ack && !r_discard) begin
          w_state_nxt = S_VALID;
        end
      end
      S_VALID: begin
        if (flush_i || !w_stop) begin
          w_state_nxt = S_WAIT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode; every output is forced to zero while reset is asserted.
  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = '0;
    if_pc       = '0;
    if_inst     = '0;
    stallreq_if = 1'b0;
    if (rst) begin
      imem_addr   = r_pc;
      imem_req    = (r_state == S_WAIT);
      stallreq_if = (r_state != S_VALID);
      if (r_state == S_VALID) begin
        if_pc   = r_pc;
        if_inst = r_inst;
      end
    end
  end

  // Datapath next values: PC redirect priority is flush, then the branch
  // presented on the consumption edge, then a captured branch, then PC+4.
  always_comb begin
    w_pc_nxt      = r_pc;
    w_inst_nxt    = r_inst;
    w_br_pend_nxt = r_br_pend;
    w_br_tgt_nxt  = r_br_tgt;
    w_discard_nxt = r_discard;
    if (flush_i) begin
      w_pc_nxt      = new_pc_i;
      w_br_pend_nxt = 1'b0;
      // An outstanding request with no ack yet will return stale data later;
      // an ack arriving this very cycle is simply dropped.
      w_discard_nxt = (r_state == S_WAIT) && !imem_ack;
    end else begin
      if (w_consume) begin
        if (branch_flag_i) begin
          w_pc_nxt = branch_target_i;
        end else if (r_br_pend) begin
          w_pc_nxt = r_br_tgt;
        end else begin
          w_pc_nxt = w_pc_inc;
        end
        w_br_pend_nxt = 1'b0;
      end else if (branch_flag_i) begin
        w_br_pend_nxt = 1'b1;
        w_br_tgt_nxt  = branch_target_i;
      end
      if (w_ack_take) begin
        if (r_discard) begin
          w_discard_nxt = 1'b0;
        end else begin
          w_inst_nxt = imem_rdata;
        end
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc      <= RESET_PC;
      r_inst    <= '0;
      r_br_pend <= 1'b0;
      r_br_tgt  <= '0;
      r_discard <= 1'b0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_inst    <= w_inst_nxt;
      r_br_pend <= w_br_pend_nxt;
      r_br_tgt  <= w_br_tgt_nxt;
      r_discard <= w_discard_nxt;
    end
  end

`ifdef IF_FETCH_CNT_EN
  logic [31:0] r_fetch_cnt;

  // Count instructions actually handed to the pipeline; wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_cnt <= '0;
    end else if (w_consume) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch. A memory responder acks requests after a
// programmable latency; tests push expected {pc, inst} pairs into a queue and a
// monitor pops and compares them whenever an instruction is consumed.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;
`ifdef IF_FETCH_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  if_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .flush_i         (flush_i),
    .new_pc_i        (new_pc_i),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .stallreq_if     (stallreq_if)
`ifdef IF_FETCH_CNT_EN
    ,
    .fetch_cnt       (fetch_cnt)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          ack_lat = 0;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_data = 32'h0;
  int          cons_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder: ack after ack_lat cycles of an asserted request.
  initial begin
    int wcnt;
    wcnt       = 0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        if (wcnt >= ack_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = ovr_en ? ovr_data : mem_word(imem_addr);
          ovr_en     = 1'b0;
          wcnt       = 0;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 32'h0;
          wcnt++;
        end
      end else begin
        imem_ack = 1'b0;
        wcnt     = 0;
      end
    end
  end

  // Scoreboard monitor: just before each rising edge, a presented instruction
  // with no stall and no flush is consumed at that edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst && !stallreq_if && !stall[0] && !flush_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: got pc=%h inst=%h, expected no instruction", if_pc, if_inst);
        end else begin
          e = exp_q.pop_front();
          if (if_pc !== e.pc || if_inst !== e.inst) begin
            errors++;
            $display("FAIL sb_consume: got pc=%h inst=%h, expected pc=%h inst=%h",
                     if_pc, if_inst, e.pc, e.inst);
          end
        end
        cons_cnt++;
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] pc);
    exp_q.push_back({pc, mem_word(pc)});
  endtask

  task automatic wait_empty(input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  task automatic wait_req_addr(input logic [31:0] addr, input int bound);
    for (int i = 0; i < bound && !(imem_req && imem_addr == addr); i++) step();
    checks++;
    if (!(imem_req && imem_addr == addr)) begin
      errors++;
      $display("FAIL wait_req: got req=%b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    stall = '0;
    branch_flag_i = 1'b0;
    branch_target_i = '0;
    flush_i = 1'b0;
    new_pc_i = '0;
    repeat (3) step();
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || stallreq_if !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: got req=%b addr=%h stallreq=%b, expected 0 0 0", imem_req, imem_addr, stallreq_if);
    end
    checks++;
    if (if_pc !== 32'h0 || if_inst !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got pc=%h inst=%h, expected 0 0", if_pc, if_inst);
    end
`ifdef IF_FETCH_CNT_EN
    checks++;
    if (fetch_cnt !== 32'h0) begin
      errors++;
      $display("FAIL reset_cnt: got %h, expected 0", fetch_cnt);
    end
`endif
  endtask

  // Zero-wait memory: 2 cycles per instruction, stallreq_if 1,1,0,1,0,1.
  task automatic test_sequence();
    logic [5:0]  pat;
    logic [31:0] a;
    pat = 6'b101011;
    ack_lat = 0;
    push(32'h0);
    push(32'h4);
    push(32'h8);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      checks++;
      if (stallreq_if !== pat[i]) begin
        errors++;
        $display("FAIL seq_stallreq[%0d]: got %b, expected %b", i, stallreq_if, pat[i]);
      end
      if (i == 1 || i == 3 || i == 5) begin
        a = 32'(i - 1) * 32'd2;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== a) begin
          errors++;
          $display("FAIL seq_req[%0d]: got req=%b addr=%h, expected req=1 addr=%h", i, imem_req, imem_addr, a);
        end
      end
    end
    wait_empty(10);
  endtask

  // Hold a presented instruction with stall[0]; release resumes at PC+4.
  task automatic test_stall();
    int n;
    push(32'hC);
    n = 0;
    while (!(stallreq_if == 1'b0 && if_pc == 32'h10) && n < 20) begin
      step();
      n++;
    end
    stall = 6'b000001;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (if_pc !== 32'h10 || if_inst !== mem_word(32'h10) || imem_req !== 1'b0 || imem_addr !== 32'h10) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got pc=%h inst=%h req=%b addr=%h, expected pc=10 inst=%h req=0 addr=10",
                 i, if_pc, if_inst, imem_req, imem_addr, mem_word(32'h10));
      end
    end
    ack_lat = 3;
    push(32'h10);
    stall = '0;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin
      errors++;
      $display("FAIL stall_release: got req=%b addr=%h, expected req=1 addr=14", imem_req, imem_addr);
    end
  endtask

  // One-cycle branch while the delay slot is still being fetched.
  task automatic test_branch_delay_slot();
    push(32'h14);
    push(32'h200);
    branch_flag_i = 1'b1;
    branch_target_i = 32'h200;
    step();
    branch_flag_i = 1'b0;
    branch_target_i = 32'h0;
    for (int i = 0; i < 20 && !(imem_req && imem_addr != 32'h14); i++) step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++;
      $display("FAIL branch_target: got req=%b addr=%h, expected req=1 addr=200", imem_req, imem_addr);
    end
    ack_lat = 6;
    wait_empty(30);
  endtask

  // Flush during a pending request: stale data is dropped, pending branch lost.
  task automatic test_flush_wait();
    wait_req_addr(32'h204, 10);
    branch_flag_i = 1'b1;
    branch_target_i = 32'h300;
    step();
    branch_flag_i = 1'b0;
    flush_i = 1'b1;
    new_pc_i = 32'h180;
    ovr_data = 32'hDEAD_BEEF;
    ovr_en = 1'b1;
    push(32'h180);
    step();
    flush_i = 1'b0;
    new_pc_i = 32'h0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h180) begin
      errors++;
      $display("FAIL flush_addr: got req=%b addr=%h, expected req=1 addr=180", imem_req, imem_addr);
    end
    wait_empty(40);
    wait_req_addr(32'h184, 5);
  endtask

  // PC wraps from FFFF_FFFC to 0; flush lands with no same-cycle ack.
  task automatic test_wrap();
    ack_lat = 0;
    flush_i = 1'b1;
    new_pc_i = 32'hFFFF_FFFC;
    push(32'hFFFF_FFFC);
    push(32'h0);
    step();
    flush_i = 1'b0;
    new_pc_i = 32'h0;
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_flush_addr: got %h, expected fffffffc", imem_addr);
    end
    for (int i = 0; i < 10 && !(imem_req && imem_addr != 32'hFFFF_FFFC); i++) step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next: got req=%b addr=%h, expected req=1 addr=0", imem_req, imem_addr);
    end
    wait_empty(10);
  endtask

  // Branch flag on the consumption edge itself redirects immediately.
  task automatic test_branch_on_consume();
    stall = 6'b111110;
    push(32'h4);
    push(32'h400);
    for (int i = 0; i < 10 && stallreq_if !== 1'b0; i++) step();
    checks++;
    if (stallreq_if !== 1'b0 || if_pc !== 32'h4) begin
      errors++;
      $display("FAIL bc_present: got stallreq=%b pc=%h, expected 0 4", stallreq_if, if_pc);
    end
    branch_flag_i = 1'b1;
    branch_target_i = 32'h400;
    step();
    branch_flag_i = 1'b0;
    branch_target_i = 32'h0;
    ack_lat = 6;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin
      errors++;
      $display("FAIL bc_target: got req=%b addr=%h, expected req=1 addr=400", imem_req, imem_addr);
    end
    wait_empty(10);
    stall = '0;
`ifdef IF_FETCH_CNT_EN
    checks++;
    if (fetch_cnt !== 32'(cons_cnt)) begin
      errors++;
      $display("FAIL cnt_total: got %0d, expected %0d", fetch_cnt, cons_cnt);
    end
`endif
  endtask

  // Asynchronous reset while a request is outstanding.
  task automatic test_reset_mid_request();
    wait_req_addr(32'h404, 5);
    rst = 1'b0;
    cons_cnt = 0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || if_inst !== 32'h0 || if_pc !== 32'h0 || stallreq_if !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got req=%b inst=%h pc=%h stallreq=%b, expected 0 0 0 0",
               imem_req, if_inst, if_pc, stallreq_if);
    end
`ifdef IF_FETCH_CNT_EN
    checks++;
    if (fetch_cnt !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_cnt: got %h, expected 0", fetch_cnt);
    end
`endif
    step();
    step();
    ack_lat = 0;
    push(RESET_PC);
    push(RESET_PC + 32'd4);
    rst = 1'b1;
    for (int i = 0; i < 5 && !imem_req; i++) step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL rst_first_addr: got req=%b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    end
    wait_empty(10);
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_stall();
    test_branch_delay_slot();
    test_flush_wait();
    test_wrap();
    test_branch_on_consume();
    test_reset_mid_request();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
